// File: rtl/pipe_alu.sv
//==============================================================================
// Module      : pipe_alu
// Description : Fixed-latency, fully pipelined ALU. One opcode-selected
//               datapath (add/sub/mul/logic/shift/compare) is computed in the
//               first stage; the remaining stages only retime the result. A
//               valid shadow chain tracks each issue strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_alu #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter bit SIGNED  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             _go,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             flag,
  output logic             out_valid
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_EQ  = 4'd9;
  localparam logic [3:0] OP_LT  = 4'd10;
  localparam logic [3:0] OP_GT  = 4'd11;
  localparam logic [3:0] OP_LTE = 4'd12;
  localparam logic [3:0] OP_GTE = 4'd13;

  // One extra top bit carries the sign (SIGNED=1) or a zero (SIGNED=0), so a
  // single signed comparison and a single arithmetic shift serve both modes.
  logic signed [WIDTH:0] w_left_ext;
  logic signed [WIDTH:0] w_right_ext;
  logic        [WIDTH:0] w_shr_ext;
  logic [WIDTH-1:0]      w_mul;
  logic [WIDTH-1:0]      w_result;
  logic                  w_cmp;
  logic                  w_is_cmp;
  logic                  w_reserved;
  logic                  w_flag;

  assign w_left_ext  = {SIGNED & left[WIDTH-1], left};
  assign w_right_ext = {SIGNED & right[WIDTH-1], right};
  // Arithmetic shift of the extended value: fill bit is the sign only when
  // SIGNED=1; oversize amounts saturate to all fill bits naturally.
  assign w_shr_ext   = w_left_ext >>> right;
  // Low WIDTH bits of the product are the same for signed and unsigned.
  assign w_mul       = left * right;

  // Stage-1 datapath: select the result and its flag from the opcode.
  always_comb begin
    w_result   = '0;
    w_cmp      = 1'b0;
    w_is_cmp   = 1'b0;
    w_reserved = 1'b0;
    case (op)
      OP_ADD: w_result = left + right;
      OP_SUB: w_result = left - right;
      OP_MUL: w_result = w_mul;
      OP_AND: w_result = left & right;
      OP_OR:  w_result = left | right;
      OP_XOR: w_result = left ^ right;
      OP_NOT: w_result = ~left;
      OP_SHL: w_result = left << right;
      OP_SHR: w_result = w_shr_ext[WIDTH-1:0];
      OP_EQ:  begin w_is_cmp = 1'b1; w_cmp = (left == right);              end
      OP_LT:  begin w_is_cmp = 1'b1; w_cmp = (w_left_ext <  w_right_ext);  end
      OP_GT:  begin w_is_cmp = 1'b1; w_cmp = (w_left_ext >  w_right_ext);  end
      OP_LTE: begin w_is_cmp = 1'b1; w_cmp = (w_left_ext <= w_right_ext);  end
      OP_GTE: begin w_is_cmp = 1'b1; w_cmp = (w_left_ext >= w_right_ext);  end
      default: w_reserved = 1'b1;
    endcase
    if (w_is_cmp) begin
      w_result = {{(WIDTH-1){1'b0}}, w_cmp};
    end
  end

  // Compare ops report their bit; reserved ops report 0; others report zero-result.
  assign w_flag = w_is_cmp ? w_cmp : (!w_reserved && (w_result == '0));

  logic [WIDTH-1:0]   r_data [LATENCY];
  logic [LATENCY-1:0] r_flag;
  logic [LATENCY-1:0] r_valid;

  // Pipeline: stage 0 captures on _go, later stages load only behind a valid bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_flag  <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_valid[0] <= _go;
      if (_go) begin
        r_data[0] <= w_result;
        r_flag[0] <= w_flag;
      end
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        if (r_valid[k-1]) begin
          r_data[k] <= r_data[k-1];
          r_flag[k] <= r_flag[k-1];
        end
      end
    end
  end

  assign out       = r_data[LATENCY-1];
  assign flag      = r_flag[LATENCY-1];
  assign out_valid = r_valid[LATENCY-1];

endmodule

`default_nettype wire

// File: doc/pipe_alu.md
Name: pipe_alu

Overview:
- Parametrised, pipelined successor to the combinational binary/logical/compare/shift primitives.
- A single opcode-selected datapath covers add, sub, multiply, logical, shift and compare.
- Result is registered over a fixed, parameter-chosen LATENCY, with a valid shadow pipeline tracking _go.
- Sits wherever the compiler needs a fixed-latency, fully pipelined arithmetic unit with one new operation accepted per cycle.

Parameters:
WIDTH, 32, operand and result width in bits (>= 2)
LATENCY, 2, cycles from _go to out_valid (>= 1)
SIGNED, 0, 1 = two's-complement compares and arithmetic right shift; 0 = unsigned/logical

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
_go  input  1  operation issue strobe; operands and op sampled when 1
op  input  4  opcode, encoding below
left  input  WIDTH  first operand / shifted value
right  input  WIDTH  second operand / shift amount
out  output  WIDTH  registered result
flag  output  1  compare result for compare ops; (result == 0) otherwise
out_valid  output  1  high exactly LATENCY cycles after each accepted _go

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. While reset == 0 at a rising edge, all valid bits, data and flag registers clear to 0. Outputs are therefore out = 0, flag = 0 and out_valid = 0 from the first edge with reset low.
- Reset mid-operation: in-flight ops are dropped. No out_valid is produced for them after reset deasserts. Reset has priority over _go in the same cycle.
- Opcodes:
  - 0 ADD: left+right mod 2^WIDTH
  - 1 SUB: left-right mod 2^WIDTH
  - 2 MUL: low WIDTH bits of the product; identical for signed and unsigned
  - 3 AND, 4 OR, 5 XOR
  - 6 NOT: ~left, right ignored
  - 7 SHL: left << right
  - 8 SHR: logical if SIGNED=0, arithmetic if SIGNED=1
  - 9 EQ, 10 LT, 11 GT, 12 LTE, 13 GTE
  - 14-15 reserved: out = 0, flag = 0, out_valid still asserted
- Shift amount: the full WIDTH-bit unsigned value of right. An amount >= WIDTH yields 0, or all sign bits for arithmetic SHR with left MSB = 1.
- Compare ops: out = zero-extended 1-bit result; flag = the same bit. EQ ignores SIGNED.
- Pipeline structure:
  - Stage 1 computes from the operands sampled at the _go edge.
  - Stages 2..LATENCY are pure retiming registers, and implementation may retime the multiplier across them.
  - Valid chain: v[0] <= _go, v[k] <= v[k-1], out_valid = v[LATENCY-1].
- No stall: the pipeline advances every cycle, giving throughput of one op/cycle with back-to-back _go allowed. Results emerge in issue order.
- Data register loading: a stage's data/flag registers load only when the valid bit entering that stage is 1; otherwise they hold. This means out/flag hold the last valid result between out_valid pulses.
- Input timing: operands are sampled only in the cycle _go = 1. They may change freely afterwards.
- No combinational path from any input to any output.

Test Plan:
1. WIDTH=8, LATENCY=3, SIGNED=0. _go=1 for one cycle at cycle 0 with op=ADD, left=200, right=100 -> at cycle 3: out_valid=1, out=44, flag=0. out_valid is 0 at cycles 1, 2 and 4.
2. op=SUB with left=5, right=5 -> out=0, flag=1. Then op=MUL with left=16, right=17 -> out=16 (272 mod 256), flag=0.
3. op=LT with left=0xFF, right=0x01: SIGNED=1 -> out=1, flag=1; SIGNED=0 -> out=0, flag=0. Then op=EQ with left=0x80, right=0x80 -> flag=1 in both modes.
4. op=SHR with left=0x80: right=2 gives 0xE0 for SIGNED=1 and 0x20 for SIGNED=0. right=9 gives 0xFF for SIGNED=1 and 0x00 for SIGNED=0. op=SHL with left=0x01, right=8 -> out=0x00.
5. Eight back-to-back _go cycles doing ADD i+i for i=1..8, then a 2-cycle gap, then op=14 -> out_valid high for cycles 3..10 with out = 2,4,...,16 in order. Out holds 16 during the gap, then out=0, flag=0 with out_valid=1 at cycle 13.
6. Issue ops at cycles 0 and 1, then drive reset=0 during cycle 2 only -> from the cycle-2 edge out=0, flag=0, out_valid=0. No out_valid appears at cycles 3 or 4. An op issued at cycle 4 emerges correctly at cycle 7.
